// File: rtl/gps_spi_packer_if.sv
// gps_spi_packer_if: sample input, overflow control/status and SPI output
// signals of the GPS sample packer, grouped as one bundle.
// master: the packer side. slave: the sample source / MCU side.
interface gps_spi_packer_if #(
    parameter int FRAME_W = 4
);
    logic               ENABLE;
    logic [FRAME_W-1:0] SAMPLE_IN;
    logic               SAMPLE_STB;
    logic               OVF_CLR;
    logic               MCU_SCK;
    logic               MCU_SS;
    logic               MCU_MOSI;
    logic [4:0]         FIFO_LEVEL;
    logic               OVERFLOW;
    logic [7:0]         OVF_COUNT;

    modport master (
        input  ENABLE, SAMPLE_IN, SAMPLE_STB, OVF_CLR,
        output MCU_SCK, MCU_SS, MCU_MOSI, FIFO_LEVEL, OVERFLOW, OVF_COUNT
    );

    modport slave (
        output ENABLE, SAMPLE_IN, SAMPLE_STB, OVF_CLR,
        input  MCU_SCK, MCU_SS, MCU_MOSI, FIFO_LEVEL, OVERFLOW, OVF_COUNT
    );
endinterface

// File: rtl/gps_spi_packer.sv
// gps_spi_packer: packs strobed GPS I/Q sample frames into SPI words,
// buffers them in a small word FIFO and shifts them out as an SPI mode-0
// master (MSB first, one word per slave-select window).
// Optional feature: define GPS_SPI_PACKER_OVF_CNT_EN to get a saturating
// dropped-word counter on OVF_COUNT; otherwise OVF_COUNT is tied to zero.
module gps_spi_packer #(
    parameter int NCH        = 1,
    parameter int SAMP_W     = 2,
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SCK_DIV    = 2
) (
    input  logic              MCU_CLK,
    input  logic              RESET_P,
    gps_spi_packer_if.master  bus
);

    localparam int FRAME_W = NCH * 2 * SAMP_W;
    localparam int FPW     = WORD_W / FRAME_W;
    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DW      = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    localparam logic [5:0]    TOP_SHIFT = 6'(WORD_W - FRAME_W);
    localparam logic [5:0]    FRAME_W6  = 6'(FRAME_W);
    localparam logic [4:0]    LAST_SLOT = 5'(FPW - 1);
    localparam logic [4:0]    DEPTH5    = 5'(FIFO_DEPTH);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SCK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [5:0]    LAST_BIT  = 6'(WORD_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} spi_state_t;

    // ---------------- frame packing ----------------
    logic [4:0]        slot_r;
    logic [WORD_W-1:0] pack_r;
    logic [WORD_W-1:0] word_r;
    logic              push_r;
    logic [5:0]        shamt_s;
    logic [WORD_W-1:0] frame_ins_s;

    // Position the incoming frame at the current slot, first slot in the MSBs.
    always_comb begin
        shamt_s     = TOP_SHIFT - (FRAME_W6 * {1'b0, slot_r});
        frame_ins_s = WORD_W'(bus.SAMPLE_IN) << shamt_s;
    end

    // Accumulate frames; a finished word is presented to the FIFO one cycle later.
    always_ff @(posedge MCU_CLK) begin
        if (RESET_P) begin
            slot_r <= 5'd0;
            pack_r <= '0;
            word_r <= '0;
            push_r <= 1'b0;
        end else begin
            push_r <= 1'b0;
            if (!bus.ENABLE) begin
                pack_r <= '0;
                slot_r <= 5'd0;
            end else if (bus.SAMPLE_STB) begin
                if (slot_r == LAST_SLOT) begin
                    word_r <= pack_r | frame_ins_s;
                    push_r <= 1'b1;
                    pack_r <= '0;
                    slot_r <= 5'd0;
                end else begin
                    pack_r <= pack_r | frame_ins_s;
                    slot_r <= slot_r + 5'd1;
                end
            end
        end
    end

    // ---------------- word FIFO ----------------
    logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [4:0]        level_r;
    logic              pop_s;
    logic              push_ok_s;
    logic              drop_s;
    spi_state_t        state_r;

    // A full FIFO still accepts a word when the shifter pops in the same cycle.
    always_comb begin
        pop_s     = (state_r == IDLE) && (level_r != 5'd0);
        push_ok_s = push_r && ((level_r != DEPTH5) || pop_s);
        drop_s    = push_r && !push_ok_s;
    end

    // FIFO storage write.
    always_ff @(posedge MCU_CLK) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= word_r;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge MCU_CLK) begin
        if (RESET_P) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= 5'd0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_r + {4'd0, push_ok_s} - {4'd0, pop_s};
        end
    end

    assign bus.FIFO_LEVEL = level_r;

    // ---------------- overflow status ----------------
    logic ovf_r;

    // Sticky drop flag; a clear wins over a drop in the same cycle.
    always_ff @(posedge MCU_CLK) begin
        if (RESET_P) begin
            ovf_r <= 1'b0;
        end else if (bus.OVF_CLR) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end
    end

    assign bus.OVERFLOW = ovf_r;

`ifdef GPS_SPI_PACKER_OVF_CNT_EN
    logic [7:0] ovf_cnt_r;

    // Saturating dropped-word counter, cleared together with the flag.
    always_ff @(posedge MCU_CLK) begin
        if (RESET_P) begin
            ovf_cnt_r <= 8'd0;
        end else if (bus.OVF_CLR) begin
            ovf_cnt_r <= 8'd0;
        end else if (drop_s && (ovf_cnt_r != 8'hFF)) begin
            ovf_cnt_r <= ovf_cnt_r + 8'd1;
        end
    end

    assign bus.OVF_COUNT = ovf_cnt_r;
`else
    assign bus.OVF_COUNT = 8'd0;
`endif

    // ---------------- SPI master ----------------
    spi_state_t        state_s;
    logic [DW-1:0]     div_r, div_s;
    logic [5:0]        bit_r, bit_s;
    logic [WORD_W-1:0] shift_r, shift_s;
    logic              sck_r, sck_s;
    logic              ss_r, ss_s;
    logic              mosi_r, mosi_s;

    // Next state and next output values; outputs are registered with the state.
    always_comb begin
        state_s = state_r;
        div_s   = div_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        sck_s   = sck_r;
        ss_s    = ss_r;
        mosi_s  = mosi_r;
        case (state_r)
            IDLE: begin
                sck_s  = 1'b0;
                div_s  = '0;
                bit_s  = 6'd0;
                if (level_r != 5'd0) begin
                    shift_s = mem_r[rd_ptr_r];
                    mosi_s  = mem_r[rd_ptr_r][WORD_W-1];
                    ss_s    = 1'b0;
                    state_s = LOAD;
                end else begin
                    ss_s    = 1'b1;
                    mosi_s  = 1'b0;
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (div_r == DIV_LAST) begin
                    div_s   = '0;
                    sck_s   = 1'b1;
                    state_s = SHIFT;
                end else begin
                    div_s = div_r + DIV_ONE;
                end
            end
            SHIFT: begin
                if (div_r == DIV_LAST) begin
                    div_s = '0;
                    if (sck_r) begin
                        // Falling edge: advance MOSI or end the word.
                        sck_s = 1'b0;
                        if (bit_r == LAST_BIT) begin
                            bit_s   = 6'd0;
                            ss_s    = 1'b1;
                            mosi_s  = 1'b0;
                            state_s = GAP;
                        end else begin
                            bit_s   = bit_r + 6'd1;
                            shift_s = {shift_r[WORD_W-2:0], 1'b0};
                            mosi_s  = shift_r[WORD_W-2];
                        end
                    end else begin
                        sck_s = 1'b1;
                    end
                end else begin
                    div_s = div_r + DIV_ONE;
                end
            end
            GAP: begin
                if (div_r == DIV_LAST) begin
                    div_s   = '0;
                    state_s = IDLE;
                end else begin
                    div_s = div_r + DIV_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                div_s   = '0;
                bit_s   = 6'd0;
                sck_s   = 1'b0;
                ss_s    = 1'b1;
                mosi_s  = 1'b0;
            end
        endcase
    end

    // SPI state and output registers; reset aborts any word in flight.
    always_ff @(posedge MCU_CLK) begin
        if (RESET_P) begin
            state_r <= IDLE;
            div_r   <= '0;
            bit_r   <= 6'd0;
            shift_r <= '0;
            sck_r   <= 1'b0;
            ss_r    <= 1'b1;
            mosi_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            div_r   <= div_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            sck_r   <= sck_s;
            ss_r    <= ss_s;
            mosi_r  <= mosi_s;
        end
    end

    assign bus.MCU_SCK  = sck_r;
    assign bus.MCU_SS   = ss_r;
    assign bus.MCU_MOSI = mosi_r;

endmodule
